// File: rtl/pcie_tx_packer.sv
// pcie_tx_packer: packs 64-bit user words into 128-bit PCIe beats and holds each beat until the
// shell grants it. Tracks the packet slot, granted-packet count and overlong-packet truncation.

package pcie_tx_packer_pkg;
    // PCIEPacket beat presented to the shell
    typedef struct packed {
        logic         valid;
        logic [127:0] data;
        logic [15:0]  slot;
        logic [3:0]   pad;
        logic         last;
    } pcie_packet_t;
endpackage

module pcie_tx_packer
    import pcie_tx_packer_pkg::*;
#(
    parameter int unsigned MAX_PKT_BEATS = 64,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    input  logic [15:0]          in_slot,
    input  logic                 in_last,
    input  logic [3:0]           in_bytes,
    output logic                 in_ready,
    output pcie_packet_t         pcie_out,
    input  logic                 pcie_grant,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 err_overlong
);

    typedef enum logic [0:0] {StLow, StHigh} state_e;

    state_e                 state_q, state_d;
    logic [63:0]            low_q, low_d;
    logic [15:0]            slot_q, slot_d;
    logic                   in_pkt_q, in_pkt_d;
    logic [15:0]            beat_cnt_q, beat_cnt_d;
    pcie_packet_t           pcie_out_q, pcie_out_d;
    logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
    logic                   err_overlong_q, err_overlong_d;

    logic                   fire;
    logic [3:0]             nb;
    logic [63:0]            masked;
    logic                   emit;
    logic                   forced;
    pcie_packet_t           beat;

    // A new word may enter whenever the output register is empty or being drained this cycle
    assign in_ready     = !pcie_out_q.valid || pcie_grant;
    assign fire         = in_valid && in_ready;
    assign pcie_out     = pcie_out_q;
    assign pkt_count    = pkt_count_q;
    assign err_overlong = err_overlong_q;

    // Byte count of the incoming word (out-of-range counts mean a full word) and its masked data
    always_comb begin
        if (!in_last || in_bytes == 4'd0 || in_bytes > 4'd8) begin
            nb = 4'd8;
        end else begin
            nb = in_bytes;
        end
        masked = '0;
        for (int i = 0; i < 8; i++) begin
            masked[i*8 +: 8] = (i < int'(nb)) ? in_data[i*8 +: 8] : 8'h00;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLow;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance only on an accepted word
    always_comb begin
        state_d = state_q;
        if (fire) begin
            unique case (state_q)
                StLow:   state_d = in_last ? StLow : StHigh;
                StHigh:  state_d = StLow;
                default: state_d = StLow;
            endcase
        end
    end

    // Output decode: build the beat emitted by this fire, if any
    always_comb begin
        emit   = 1'b0;
        forced = 1'b0;
        beat   = '0;
        unique case (state_q)
            StLow: begin
                if (fire && in_last) begin
                    emit      = 1'b1;
                    beat.data = {64'h0, masked};
                    beat.pad  = 4'(16 - int'(nb));
                    beat.last = 1'b1;
                end
            end
            StHigh: begin
                if (fire) begin
                    emit      = 1'b1;
                    beat.data = {masked, low_q};
                    beat.pad  = in_last ? 4'(8 - int'(nb)) : 4'd0;
                    beat.last = in_last;
                end
            end
            default: ;
        endcase
        // Truncate a packet that reaches the beat limit without ending
        if (emit && !beat.last && beat_cnt_q == 16'(MAX_PKT_BEATS - 1)) begin
            forced    = 1'b1;
            beat.last = 1'b1;
            beat.pad  = 4'd0;
        end
        beat.valid = emit;
        beat.slot  = in_pkt_q ? slot_q : in_slot;
    end

    // Datapath next-state: low word, slot tracking, beat count, output register, status
    always_comb begin
        low_d = low_q;
        if (state_q == StLow && fire && !in_last) begin
            low_d = in_data;
        end

        slot_d   = slot_q;
        in_pkt_d = in_pkt_q;
        if (fire && !in_pkt_q) begin
            slot_d   = in_slot;
            in_pkt_d = 1'b1;
        end
        if (emit && beat.last) begin
            in_pkt_d = 1'b0;
        end

        beat_cnt_d = beat_cnt_q;
        if (emit) begin
            beat_cnt_d = beat.last ? 16'd0 : beat_cnt_q + 16'd1;
        end

        // A new beat overwrites one being granted in the same cycle, so there is no bubble
        pcie_out_d = pcie_out_q;
        if (emit) begin
            pcie_out_d = beat;
        end else if (pcie_out_q.valid && pcie_grant) begin
            pcie_out_d = '0;
        end

        pkt_count_d = pkt_count_q;
        if (pcie_out_q.valid && pcie_grant && pcie_out_q.last) begin
            pkt_count_d = pkt_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end

        err_overlong_d = err_overlong_q | forced;
    end

    // Datapath registers; reset discards any partial word or pending beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_q          <= '0;
            slot_q         <= '0;
            in_pkt_q       <= 1'b0;
            beat_cnt_q     <= '0;
            pcie_out_q     <= '0;
            pkt_count_q    <= '0;
            err_overlong_q <= 1'b0;
        end else begin
            low_q          <= low_d;
            slot_q         <= slot_d;
            in_pkt_q       <= in_pkt_d;
            beat_cnt_q     <= beat_cnt_d;
            pcie_out_q     <= pcie_out_d;
            pkt_count_q    <= pkt_count_d;
            err_overlong_q <= err_overlong_d;
        end
    end

endmodule

// File: tb/tb_pcie_tx_packer.sv
// Testbench for pcie_tx_packer: two instances (beat limits 64 and 2) share one input stream;
// expected beats are queued per instance and a monitor compares every granted beat.

module tb_pcie_tx_packer;
    import pcie_tx_packer_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [63:0]  in_data;
    logic [15:0]  in_slot;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic         pcie_grant;
    logic         in_ready_a, in_ready_b;
    pcie_packet_t out_a, out_b;
    logic [31:0]  cnt_a, cnt_b;
    logic         err_a, err_b;

    int           checks = 0;
    int           errors = 0;
    int           exp_cnt_a = 0;
    int           exp_cnt_b = 0;
    pcie_packet_t qa[$];
    pcie_packet_t qb[$];
    logic [63:0]  w[7];

    always #5 clk = ~clk;

    pcie_tx_packer #(.MAX_PKT_BEATS(64), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_slot(in_slot),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready_a), .pcie_out(out_a),
        .pcie_grant(pcie_grant), .pkt_count(cnt_a), .err_overlong(err_a)
    );

    pcie_tx_packer #(.MAX_PKT_BEATS(2), .CNT_WIDTH(32)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_slot(in_slot),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready_b), .pcie_out(out_b),
        .pcie_grant(pcie_grant), .pkt_count(cnt_b), .err_overlong(err_b)
    );

    function automatic pcie_packet_t mk(input logic [127:0] d, input logic [15:0] s,
                                        input logic [3:0] p, input logic l);
        pcie_packet_t b;
        b.valid = 1'b1;
        b.data  = d;
        b.slot  = s;
        b.pad   = p;
        b.last  = l;
        return b;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push2(input pcie_packet_t a, input pcie_packet_t b);
        qa.push_back(a);
        qb.push_back(b);
        if (a.last) exp_cnt_a++;
        if (b.last) exp_cnt_b++;
    endtask

    // Compares every beat the shell consumes against the head of the matching queue
    task automatic monitor();
        pcie_packet_t e;
        forever begin
            @(negedge clk);
            if (!rst && pcie_grant && out_a.valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL beat_a: unexpected beat data=%h", out_a.data);
                end else begin
                    e = qa.pop_front();
                    if (out_a !== e) begin
                        errors++;
                        $display("FAIL beat_a: got data=%h slot=%h pad=%0d last=%b expected data=%h slot=%h pad=%0d last=%b",
                                 out_a.data, out_a.slot, out_a.pad, out_a.last,
                                 e.data, e.slot, e.pad, e.last);
                    end
                end
            end
            if (!rst && pcie_grant && out_b.valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_b: unexpected beat data=%h", out_b.data);
                end else begin
                    e = qb.pop_front();
                    if (out_b !== e) begin
                        errors++;
                        $display("FAIL beat_b: got data=%h slot=%h pad=%0d last=%b expected data=%h slot=%h pad=%0d last=%b",
                                 out_b.data, out_b.slot, out_b.pad, out_b.last,
                                 e.data, e.slot, e.pad, e.last);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [15:0] s, input logic l,
                        input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_slot  = s;
        in_last  = l;
        in_bytes = b;
        @(negedge clk);
        while (!in_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_and_count(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d/%0d beats still expected, required 0", name,
                     qa.size(), qb.size());
        end
        @(posedge clk);
        #1;
        check({name, "_count_a"}, 160'(cnt_a), 160'(exp_cnt_a));
        check({name, "_count_b"}, 160'(cnt_b), 160'(exp_cnt_b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pcie_packet_t bw;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_slot    = '0;
        in_last    = 1'b0;
        in_bytes   = '0;
        pcie_grant = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 160'(out_a), 160'(0));
        check("rst_ready", 160'(in_ready_a), 160'(1));
        check("rst_count", 160'(cnt_a), 160'(0));
        check("rst_err", 160'(err_a), 160'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single full word
        bw = mk({64'h0, 64'h1122334455667788}, 16'd5, 4'd8, 1'b1);
        push2(bw, bw);
        send(64'h1122334455667788, 16'd5, 1'b1, 4'd8);
        drain_and_count("t1");

        // 2: two words, last has 3 bytes
        bw = mk({64'h0000000000B2B1B0, 64'hA7A6A5A4A3A2A1A0}, 16'd2, 4'd5, 1'b1);
        push2(bw, bw);
        send(64'hA7A6A5A4A3A2A1A0, 16'd2, 1'b0, 4'd0);
        send(64'hB7B6B5B4B3B2B1B0, 16'd0, 1'b1, 4'd3);
        drain_and_count("t2");

        // Byte-count clamping and edge sizes
        bw = mk({64'h0, 64'h0123456789ABCDEF}, 16'd1, 4'd8, 1'b1);
        push2(bw, bw);
        bw = mk({64'h0, 64'hFEDCBA9876543210}, 16'd1, 4'd8, 1'b1);
        push2(bw, bw);
        bw = mk({64'h0, 64'h00000000000000FF}, 16'd1, 4'd15, 1'b1);
        push2(bw, bw);
        bw = mk({64'h2222222222222222, 64'h1111111111111111}, 16'd3, 4'd0, 1'b1);
        push2(bw, bw);
        send(64'h0123456789ABCDEF, 16'd1, 1'b1, 4'd0);
        send(64'hFEDCBA9876543210, 16'd1, 1'b1, 4'd12);
        send(64'hFFFFFFFFFFFFFFFF, 16'd1, 1'b1, 4'd1);
        send(64'h1111111111111111, 16'd3, 1'b0, 4'd0);
        send(64'h2222222222222222, 16'd9, 1'b1, 4'd8);
        drain_and_count("clamp");
        check("no_err_b", 160'(err_b), 160'(0));

        // 4: back-pressure for 10 cycles, then grant accepts the waiting word the same cycle
        pcie_grant = 1'b0;
        bw = mk({64'h0, 64'h5555666677778888}, 16'd4, 4'd8, 1'b1);
        push2(bw, bw);
        send(64'h5555666677778888, 16'd4, 1'b1, 4'd8);
        in_valid = 1'b1;
        in_data  = 64'h9999AAAABBBBCCCC;
        in_slot  = 16'd6;
        in_last  = 1'b1;
        in_bytes = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready", 160'(in_ready_a), 160'(0));
            check("bp_hold_a", 160'(out_a), 160'(bw));
        end
        @(posedge clk);
        #1;
        pcie_grant = 1'b1;
        bw = mk({64'h0, 64'h000000000000CCCC}, 16'd6, 4'd14, 1'b1);
        push2(bw, bw);
        @(negedge clk);
        check("grant_ready", 160'(in_ready_a), 160'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain_and_count("t4");

        // 5: six non-last words then a last word; instance b truncates at 2 beats
        for (int i = 0; i < 7; i++) w[i] = 64'(i + 1) * 64'h0101010101010101;
        push2(mk({w[1], w[0]}, 16'h11, 4'd0, 1'b0), mk({w[1], w[0]}, 16'h11, 4'd0, 1'b0));
        push2(mk({w[3], w[2]}, 16'h11, 4'd0, 1'b0), mk({w[3], w[2]}, 16'h11, 4'd0, 1'b1));
        push2(mk({w[5], w[4]}, 16'h11, 4'd0, 1'b0), mk({w[5], w[4]}, 16'h15, 4'd0, 1'b0));
        push2(mk({64'h0, w[6]}, 16'h11, 4'd8, 1'b1), mk({64'h0, w[6]}, 16'h15, 4'd8, 1'b1));
        for (int i = 0; i < 6; i++) send(w[i], 16'(16'h11 + i), 1'b0, 4'd0);
        send(w[6], 16'h17, 1'b1, 4'd8);
        drain_and_count("t5");
        check("overlong_a", 160'(err_a), 160'(0));
        check("overlong_b", 160'(err_b), 160'(1));

        // 3: five words, slot changes mid-packet are ignored
        for (int i = 0; i < 5; i++) w[i] = {8{8'(8'hE0 + i)}};
        push2(mk({w[1], w[0]}, 16'd7, 4'd0, 1'b0), mk({w[1], w[0]}, 16'd7, 4'd0, 1'b0));
        push2(mk({w[3], w[2]}, 16'd7, 4'd0, 1'b0), mk({w[3], w[2]}, 16'd7, 4'd0, 1'b1));
        push2(mk({64'h0, w[4]}, 16'd7, 4'd8, 1'b1), mk({64'h0, w[4]}, 16'd0, 4'd8, 1'b1));
        send(w[0], 16'd7, 1'b0, 4'd0);
        send(w[1], 16'd0, 1'b0, 4'd0);
        send(w[2], 16'd9, 1'b0, 4'd0);
        send(w[3], 16'd0, 1'b0, 4'd0);
        send(w[4], 16'd0, 1'b1, 4'd8);
        drain_and_count("t3");

        // 6: reset with a pending beat, then reset while holding a low word
        pcie_grant = 1'b0;
        send(64'hDEADBEEFDEADBEEF, 16'd2, 1'b1, 4'd8);
        #2;
        rst = 1'b1;
        #1;
        check("rst_pending_a", 160'(out_a.valid), 160'(0));
        check("rst_pending_b", 160'(out_b.valid), 160'(0));
        check("rst_ready2", 160'(in_ready_a), 160'(1));
        check("rst_count2", 160'(cnt_a), 160'(0));
        check("rst_err2", 160'(err_b), 160'(0));
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        pcie_grant = 1'b1;
        send(64'h7777777777777777, 16'd1, 1'b0, 4'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bw = mk({64'h0, 64'h3333333333333333}, 16'd3, 4'd8, 1'b1);
        push2(bw, bw);
        send(64'h3333333333333333, 16'd3, 1'b1, 4'd8);
        drain_and_count("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
